// File: rtl/issue_queue_if.sv
// Dispatch/issue bundle for issue_queue.
// Ports (slave = queue side):
//   in : i_regs, i_func, i_ctrl, i_imm, i_brmask, i_rs1_rdy, i_rs2_rdy,
//        i_wake_en, i_wake_tag, i_issue_stall, i_flush
//   out: o_full, o_empty, o_count, o_issue_valid, o_issue_regs,
//        o_issue_func, o_issue_imm, o_issue_brmask
interface issue_queue_if #(
   parameter int unsigned DEPTH     = 8,
   parameter int unsigned WIDTH_BRM = 6
);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic [14:0]          i_regs;
   logic [9:0]           i_func;
   logic [4:0]           i_ctrl;
   logic [31:0]          i_imm;
   logic [WIDTH_BRM-1:0] i_brmask;
   logic                 i_rs1_rdy;
   logic                 i_rs2_rdy;
   logic                 i_wake_en;
   logic [4:0]           i_wake_tag;
   logic                 i_issue_stall;
   logic                 i_flush;

   logic                 o_full;
   logic                 o_empty;
   logic [CW-1:0]        o_count;
   logic                 o_issue_valid;
   logic [14:0]          o_issue_regs;
   logic [9:0]           o_issue_func;
   logic [31:0]          o_issue_imm;
   logic [WIDTH_BRM-1:0] o_issue_brmask;

   modport master (
      output i_regs, i_func, i_ctrl, i_imm, i_brmask, i_rs1_rdy, i_rs2_rdy,
             i_wake_en, i_wake_tag, i_issue_stall, i_flush,
      input  o_full, o_empty, o_count, o_issue_valid, o_issue_regs,
             o_issue_func, o_issue_imm, o_issue_brmask
   );

   modport slave (
      input  i_regs, i_func, i_ctrl, i_imm, i_brmask, i_rs1_rdy, i_rs2_rdy,
             i_wake_en, i_wake_tag, i_issue_stall, i_flush,
      output o_full, o_empty, o_count, o_issue_valid, o_issue_regs,
             o_issue_func, o_issue_imm, o_issue_brmask
   );
endinterface

// File: rtl/issue_queue.sv
// Collapsing, oldest-first issue queue. Holds decoded micro-ops for one queue
// type until both sources are ready and issues one per cycle; priority-11
// micro-ops (branches/jumps) win selection. Full flush on misprediction.
// Ports:
//   i_clk  : clock, rising edge
//   i_rst  : synchronous active-high reset
//   bus    : issue_queue_if.slave (dispatch in, wakeup, stall/flush, issue out)
// Optional macro IQ_WAKEUP_BYPASS_EN: a wakeup in the dispatch cycle also
// marks the matching source of the micro-op being dispatched as ready.
module issue_queue #(
   parameter int unsigned DEPTH     = 8,
   parameter int unsigned WIDTH_BRM = 6,
   parameter logic [1:0]  QTYPE     = 2'b10
) (
   input logic          i_clk,
   input logic          i_rst,
   issue_queue_if.slave bus
);
   localparam int unsigned IW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [14:0]          regs;
      logic [9:0]           func;
      logic [31:0]          imm;
      logic [1:0]           pry;
      logic [WIDTH_BRM-1:0] brmask;
      logic                 rdy1;
      logic                 rdy2;
   } entry_t;

   entry_t           ent_q [DEPTH];
   entry_t           ent_d [DEPTH];
   logic [DEPTH-1:0] vld_q, vld_d;
   logic [CW-1:0]    cnt_q, cnt_d, cnt_post;
   entry_t           new_ent;
   logic [DEPTH-1:0] cand;
   logic             sel_found, pri_found, issue_valid, issue_fire, accept, wake_ok;
   logic [IW-1:0]    sel_idx, pri_idx, pick, wr_idx;

   assign wake_ok    = bus.i_wake_en & (bus.i_wake_tag != 5'd0);
   assign accept     = bus.i_ctrl[0] & (bus.i_ctrl[2:1] == QTYPE) &
                       (cnt_q != CW'(DEPTH)) & ~bus.i_flush;
   assign issue_fire = issue_valid & ~bus.i_issue_stall;

   // Selection: lowest-index ready entry, priority-11 entries first
   always_comb begin
      cand      = '0;
      sel_found = 1'b0;
      pri_found = 1'b0;
      sel_idx   = '0;
      pri_idx   = '0;
      for (int i = 0; i < int'(DEPTH); i++)
         cand[i] = vld_q[i] & ent_q[i].rdy1 & ent_q[i].rdy2;
      // Descending scan so the last hit is the lowest index
      for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
         if (cand[i]) begin
            sel_found = 1'b1;
            sel_idx   = IW'(i);
            if (ent_q[i].pry == 2'b11) begin
               pri_found = 1'b1;
               pri_idx   = IW'(i);
            end
         end
      end
      pick = pri_found ? pri_idx : sel_idx;
   end

   assign issue_valid        = sel_found & ~bus.i_flush;
   assign bus.o_issue_valid  = issue_valid;
   assign bus.o_issue_regs   = issue_valid ? ent_q[pick].regs   : '0;
   assign bus.o_issue_func   = issue_valid ? ent_q[pick].func   : '0;
   assign bus.o_issue_imm    = issue_valid ? ent_q[pick].imm    : '0;
   assign bus.o_issue_brmask = issue_valid ? ent_q[pick].brmask : '0;
   assign bus.o_count        = cnt_q;
   assign bus.o_full         = (cnt_q == CW'(DEPTH));
   assign bus.o_empty        = (cnt_q == '0);

   // Incoming micro-op; x0 is always ready
   always_comb begin
      new_ent.regs   = bus.i_regs;
      new_ent.func   = bus.i_func;
      new_ent.imm    = bus.i_imm;
      new_ent.pry    = bus.i_ctrl[4:3];
      new_ent.brmask = bus.i_brmask;
      new_ent.rdy1   = bus.i_rs1_rdy | (bus.i_regs[4:0] == 5'd0);
      new_ent.rdy2   = bus.i_rs2_rdy | (bus.i_regs[9:5] == 5'd0);
`ifdef IQ_WAKEUP_BYPASS_EN
      // Busy-table read racing with writeback in the same cycle
      if (wake_ok && (bus.i_wake_tag == bus.i_regs[4:0])) new_ent.rdy1 = 1'b1;
      if (wake_ok && (bus.i_wake_tag == bus.i_regs[9:5])) new_ent.rdy2 = 1'b1;
`endif
   end

   // Next state: wakeup, then collapse on issue, then append dispatch
   always_comb begin
      ent_d    = ent_q;
      vld_d    = vld_q;
      cnt_post = cnt_q;
      cnt_d    = cnt_q;
      wr_idx   = '0;
      if (wake_ok) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            if (vld_q[i]) begin
               if (ent_q[i].regs[4:0] == bus.i_wake_tag) ent_d[i].rdy1 = 1'b1;
               if (ent_q[i].regs[9:5] == bus.i_wake_tag) ent_d[i].rdy2 = 1'b1;
            end
         end
      end
      if (issue_fire) begin
         // Ascending order: slot i+1 is still unmodified when copied down
         for (int i = 0; i < int'(DEPTH) - 1; i++) begin
            if (IW'(i) >= pick) begin
               ent_d[i] = ent_d[i+1];
               vld_d[i] = vld_d[i+1];
            end
         end
         vld_d[DEPTH-1] = 1'b0;
         cnt_post       = cnt_q - CW'(1);
      end
      // accept implies cnt_post < DEPTH, so the truncation is lossless
      wr_idx = IW'(cnt_post);
      if (accept) begin
         ent_d[wr_idx] = new_ent;
         vld_d[wr_idx] = 1'b1;
         cnt_d         = cnt_post + CW'(1);
      end else begin
         cnt_d = cnt_post;
      end
   end

   // State registers; flush drops everything, reset also scrubs payloads
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         vld_q <= '0;
         cnt_q <= '0;
         for (int i = 0; i < int'(DEPTH); i++) ent_q[i] <= '0;
      end else if (bus.i_flush) begin
         vld_q <= '0;
         cnt_q <= '0;
      end else begin
         ent_q <= ent_d;
         vld_q <= vld_d;
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: tb/tb_issue_queue.sv
// Self-checking bench for issue_queue: scoreboard of expected {imm, regs}
// pushed at dispatch, popped when the queue issues.
module tb_issue_queue;
   localparam int unsigned DEPTH     = 8;
   localparam int unsigned WIDTH_BRM = 6;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   issue_queue_if #(.DEPTH(DEPTH), .WIDTH_BRM(WIDTH_BRM)) bus ();

   issue_queue #(.DEPTH(DEPTH), .WIDTH_BRM(WIDTH_BRM), .QTYPE(2'b10)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   int          errors = 0;
   int          checks = 0;
   logic [46:0] exp_q[$];
   logic [46:0] exp_v;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.i_regs        = '0;
      bus.i_func        = '0;
      bus.i_ctrl        = '0;
      bus.i_imm         = '0;
      bus.i_brmask      = '0;
      bus.i_rs1_rdy     = 1'b0;
      bus.i_rs2_rdy     = 1'b0;
      bus.i_wake_en     = 1'b0;
      bus.i_wake_tag    = '0;
      bus.i_issue_stall = 1'b0;
      bus.i_flush       = 1'b0;
   endtask

   function automatic logic [46:0] pack(input logic [4:0] rd, rs1, rs2);
      return {32'hC000_0000 | 32'(rd), rd, rs2, rs1};
   endfunction

   function automatic logic [46:0] issued();
      return {bus.o_issue_imm, bus.o_issue_regs};
   endfunction

   task automatic set_op(input logic [4:0] rd, rs1, rs2, input logic r1, r2,
                         input logic [1:0] pry, q);
      bus.i_regs    = {rd, rs2, rs1};
      bus.i_func    = {7'(rd), 3'(rd)};
      bus.i_ctrl    = {pry, q, 1'b1};
      bus.i_imm     = 32'hC000_0000 | 32'(rd);
      bus.i_brmask  = 6'(rd);
      bus.i_rs1_rdy = r1;
      bus.i_rs2_rdy = r2;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle();
      tick();
      tick();
      rst = 1'b0;
      #1;
      checks++;
      if ({bus.o_empty, bus.o_full, bus.o_count, bus.o_issue_valid} !== {1'b1, 1'b0, 4'd0, 1'b0}) begin
         errors++;
         $display("FAIL reset_status: got e=%b f=%b c=%0d v=%b want e=1 f=0 c=0 v=0",
                  bus.o_empty, bus.o_full, bus.o_count, bus.o_issue_valid);
      end
      checks++;
      if ({bus.o_issue_regs, bus.o_issue_func, bus.o_issue_imm, bus.o_issue_brmask} !== '0) begin
         errors++;
         $display("FAIL reset_data: got regs=%h imm=%h want 0", bus.o_issue_regs, bus.o_issue_imm);
      end
   endtask

   // Three ready ops back to back issue in order, one cycle after acceptance
   task automatic test_back_to_back();
      for (int c = 0; c < 4; c++) begin
         idle();
         if (c < 3) begin
            set_op(5'(c + 1), 5'd1, 5'd2, 1'b1, 1'b1, 2'b00, 2'b10);
            exp_q.push_back(pack(5'(c + 1), 5'd1, 5'd2));
         end
         #1;
         checks++;
         if (bus.o_issue_valid !== (c != 0)) begin
            errors++;
            $display("FAIL b2b_valid c=%0d: got %b want %b", c, bus.o_issue_valid, c != 0);
         end
         if (c != 0) begin
            exp_v = exp_q.pop_front();
            checks++;
            if (issued() !== exp_v) begin
               errors++;
               $display("FAIL b2b_data c=%0d: got %h want %h", c, issued(), exp_v);
            end
         end
         tick();
      end
      idle();
      #1;
      checks++;
      if ({bus.o_empty, bus.o_issue_valid} !== 2'b10) begin
         errors++;
         $display("FAIL b2b_empty: got e=%b v=%b want e=1 v=0", bus.o_empty, bus.o_issue_valid);
      end
   endtask

   // Fill with blocked ops, drop a 9th, then wake all of them
   task automatic test_full_wakeup();
      for (int i = 0; i < 8; i++) begin
         idle();
         set_op(5'(i + 1), 5'd5, 5'd0, 1'b0, 1'b0, 2'b00, 2'b10);
         exp_q.push_back(pack(5'(i + 1), 5'd5, 5'd0));
         tick();
      end
      idle();
      #1;
      checks++;
      if ({bus.o_full, bus.o_count, bus.o_issue_valid} !== {1'b1, 4'd8, 1'b0}) begin
         errors++;
         $display("FAIL full_status: got f=%b c=%0d v=%b want f=1 c=8 v=0",
                  bus.o_full, bus.o_count, bus.o_issue_valid);
      end
      set_op(5'd9, 5'd0, 5'd0, 1'b1, 1'b1, 2'b00, 2'b10);
      tick();
      idle();
      #1;
      checks++;
      if ({bus.o_count, bus.o_issue_valid} !== {4'd8, 1'b0}) begin
         errors++;
         $display("FAIL full_drop: got c=%0d v=%b want c=8 v=0", bus.o_count, bus.o_issue_valid);
      end
      bus.i_wake_en  = 1'b1;
      bus.i_wake_tag = 5'd5;
      #1;
      checks++;
      if (bus.o_issue_valid !== 1'b0) begin
         errors++;
         $display("FAIL wake_latency: got %b want 0", bus.o_issue_valid);
      end
      tick();
      idle();
      for (int i = 0; i < 8; i++) begin
         #1;
         checks++;
         if (bus.o_issue_valid !== 1'b1) begin
            errors++;
            $display("FAIL wake_valid i=%0d: got %b want 1", i, bus.o_issue_valid);
         end
         exp_v = exp_q.pop_front();
         checks++;
         if (issued() !== exp_v) begin
            errors++;
            $display("FAIL wake_data i=%0d: got %h want %h", i, issued(), exp_v);
         end
         tick();
      end
      #1;
      checks++;
      if (bus.o_empty !== 1'b1) begin
         errors++;
         $display("FAIL wake_drained: got empty=%b want 1", bus.o_empty);
      end
   endtask

   // Priority-11 op overtakes an older ordinary op; MEMQ code ignored
   task automatic test_priority();
      idle();
      set_op(5'd10, 5'd1, 5'd2, 1'b1, 1'b1, 2'b00, 2'b10);
      bus.i_issue_stall = 1'b1;
      exp_q.push_back(pack(5'd10, 5'd1, 5'd2));
      tick();
      idle();
      set_op(5'd11, 5'd3, 5'd4, 1'b1, 1'b1, 2'b11, 2'b10);
      bus.i_issue_stall = 1'b1;
      #1;
      checks++;
      if ({bus.o_issue_valid, issued()} !== {1'b1, exp_q[0]}) begin
         errors++;
         $display("FAIL pry_before: got v=%b %h want v=1 %h", bus.o_issue_valid, issued(), exp_q[0]);
      end
      exp_q.push_front(pack(5'd11, 5'd3, 5'd4));
      tick();
      for (int c = 0; c < 2; c++) begin
         idle();
         if (c == 0) set_op(5'd20, 5'd1, 5'd1, 1'b1, 1'b1, 2'b00, 2'b01);
         #1;
         exp_v = exp_q.pop_front();
         checks++;
         if ({bus.o_issue_valid, issued()} !== {1'b1, exp_v}) begin
            errors++;
            $display("FAIL pry_order c=%0d: got v=%b %h want v=1 %h", c, bus.o_issue_valid, issued(), exp_v);
         end
         tick();
      end
      idle();
      #1;
      checks++;
      if ({bus.o_empty, bus.o_issue_valid} !== 2'b10) begin
         errors++;
         $display("FAIL memq_ignored: got e=%b v=%b want e=1 v=0", bus.o_empty, bus.o_issue_valid);
      end
   endtask

   // Stall holds the selected op in place
   task automatic test_stall();
      idle();
      set_op(5'd13, 5'd8, 5'd9, 1'b1, 1'b1, 2'b00, 2'b10);
      exp_q.push_back(pack(5'd13, 5'd8, 5'd9));
      tick();
      idle();
      bus.i_issue_stall = 1'b1;
      for (int s = 0; s < 3; s++) begin
         #1;
         checks++;
         if ({bus.o_issue_valid, bus.o_count, issued()} !== {1'b1, 4'd1, exp_q[0]}) begin
            errors++;
            $display("FAIL stall_hold s=%0d: got v=%b c=%0d %h want v=1 c=1 %h",
                     s, bus.o_issue_valid, bus.o_count, issued(), exp_q[0]);
         end
         tick();
      end
      idle();
      #1;
      exp_v = exp_q.pop_front();
      checks++;
      if ({bus.o_issue_valid, issued()} !== {1'b1, exp_v}) begin
         errors++;
         $display("FAIL stall_release: got v=%b %h want v=1 %h", bus.o_issue_valid, issued(), exp_v);
      end
      tick();
      #1;
      checks++;
      if ({bus.o_count, bus.o_empty} !== {4'd0, 1'b1}) begin
         errors++;
         $display("FAIL stall_removed: got c=%0d e=%b want c=0 e=1", bus.o_count, bus.o_empty);
      end
   endtask

   // Flush with concurrent dispatch empties the queue and drops the dispatch
   task automatic test_flush();
      for (int i = 0; i < 5; i++) begin
         idle();
         set_op(5'(i + 21), 5'd1, 5'd2, 1'b1, 1'b1, 2'b00, 2'b10);
         bus.i_issue_stall = 1'b1;
         exp_q.push_back(pack(5'(i + 21), 5'd1, 5'd2));
         tick();
      end
      idle();
      bus.i_issue_stall = 1'b1;
      #1;
      checks++;
      if ({bus.o_count, bus.o_issue_valid} !== {4'd5, 1'b1}) begin
         errors++;
         $display("FAIL flush_pre: got c=%0d v=%b want c=5 v=1", bus.o_count, bus.o_issue_valid);
      end
      idle();
      set_op(5'd30, 5'd1, 5'd2, 1'b1, 1'b1, 2'b00, 2'b10);
      bus.i_flush = 1'b1;
      #1;
      checks++;
      if (bus.o_issue_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_valid: got %b want 0", bus.o_issue_valid);
      end
      exp_q.delete();
      tick();
      idle();
      #1;
      checks++;
      if ({bus.o_count, bus.o_empty, bus.o_issue_valid} !== {4'd0, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL flush_after: got c=%0d e=%b v=%b want c=0 e=1 v=0",
                  bus.o_count, bus.o_empty, bus.o_issue_valid);
      end
   endtask

   // Wakeup arriving in the dispatch cycle of the waiting op
   task automatic test_same_cycle_wake();
      idle();
      set_op(5'd14, 5'd0, 5'd7, 1'b1, 1'b0, 2'b00, 2'b10);
      bus.i_wake_en  = 1'b1;
      bus.i_wake_tag = 5'd7;
      exp_q.push_back(pack(5'd14, 5'd0, 5'd7));
      tick();
      idle();
`ifndef IQ_WAKEUP_BYPASS_EN
      for (int s = 0; s < 3; s++) begin
         #1;
         checks++;
         if ({bus.o_issue_valid, bus.o_count} !== {1'b0, 4'd1}) begin
            errors++;
            $display("FAIL nobypass_stuck s=%0d: got v=%b c=%0d want v=0 c=1",
                     s, bus.o_issue_valid, bus.o_count);
         end
         tick();
      end
      bus.i_wake_en  = 1'b1;
      bus.i_wake_tag = 5'd7;
      tick();
      idle();
`endif
      #1;
      exp_v = exp_q.pop_front();
      checks++;
      if ({bus.o_issue_valid, issued()} !== {1'b1, exp_v}) begin
         errors++;
         $display("FAIL wake_race_issue: got v=%b %h want v=1 %h", bus.o_issue_valid, issued(), exp_v);
      end
      tick();
      #1;
      checks++;
      if (bus.o_empty !== 1'b1) begin
         errors++;
         $display("FAIL wake_race_empty: got %b want 1", bus.o_empty);
      end
   endtask

   // Reset while holding ready entries clears state and data outputs
   task automatic test_reset_mid();
      for (int i = 0; i < 2; i++) begin
         idle();
         set_op(5'(i + 1), 5'd1, 5'd2, 1'b1, 1'b1, 2'b00, 2'b10);
         bus.i_issue_stall = 1'b1;
         tick();
      end
      idle();
      bus.i_issue_stall = 1'b1;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      idle();
      #1;
      checks++;
      if ({bus.o_issue_valid, bus.o_count, bus.o_empty, bus.o_issue_regs, bus.o_issue_imm}
          !== {1'b0, 4'd0, 1'b1, 15'd0, 32'd0}) begin
         errors++;
         $display("FAIL reset_mid: got v=%b c=%0d e=%b regs=%h imm=%h want v=0 c=0 e=1 regs=0 imm=0",
                  bus.o_issue_valid, bus.o_count, bus.o_empty, bus.o_issue_regs, bus.o_issue_imm);
      end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_full_wakeup();
      test_priority();
      test_stall();
      test_flush();
      test_same_cycle_wake();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
